tmds_decoder: RTL and testbench

Receive-side counterpart of the TMDS encoder, one instance per TMDS channel.
- Takes raw 10-bit words from the 1:10 input deserializer, already in the pixel clock domain.
- Finds the 10-bit word boundary by sliding a window over the control tokens sent during blanking.
- Decodes 10b to 8b and recovers data_en and the ctrl0/ctrl1 control signals.
- Feeds the receive video path (sync and timing recovery, pixel capture).

---
 rtl/tmds_pkg.sv | 25 ++
 rtl/tmds_word_aligner.sv | 123 ++++++++++++
 rtl/tmds_decoder.sv | 119 +++++++++++
 tb/tb_tmds_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS definitions for the encoder/decoder pair.
// Contents: TMDS_WORD_W, the four CTRL_TOKEN_* control tokens, the alignment
// state enum and an is_token() helper.
package tmds_pkg;

    localparam int TMDS_WORD_W = 10;

    // Control tokens as sent on the wire: bit 0 is transmitted first.
    localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_0 = 10'b1101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        LOCKED
    } align_state_t;

    function automatic logic is_token(input logic [TMDS_WORD_W-1:0] w);
        return (w == CTRL_TOKEN_0) || (w == CTRL_TOKEN_1) ||
               (w == CTRL_TOKEN_2) || (w == CTRL_TOKEN_3);
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// tmds_word_aligner: sliding 10-bit window over the deserialized stream plus
// the SEARCH/SETTLE/LOCKED alignment FSM driven by control-token detection.
// Ports:
//   clk, rst_n  - pixel clock, asynchronous active-low reset
//   i_din       - raw deserialized word, bit 0 received first
//   o_word_al   - registered, aligned 10-bit word
//   o_locked    - alignment established
//   o_offset    - current window offset, 0..9
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 1024,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TMDS_WORD_W-1:0] i_din,
    output logic [TMDS_WORD_W-1:0] o_word_al,
    output logic                   o_locked,
    output logic [3:0]             o_offset
);

    localparam int CNT_W = $clog2(SEARCH_WORDS > LOCK_TIMEOUT ? SEARCH_WORDS : LOCK_TIMEOUT) + 1;

    logic [TMDS_WORD_W-1:0] r_din_prev;
    logic [TMDS_WORD_W-1:0] r_word_al;
    align_state_t           r_state;
    logic [3:0]             r_offset;
    logic [CNT_W-1:0]       r_tok_run;
    logic [CNT_W-1:0]       r_idle;
    logic                   r_settle;

    logic [TMDS_WORD_W-1:0] w_win;
    logic                   w_tok;
    align_state_t           w_state_nx;
    logic [3:0]             w_offset_nx;
    logic [CNT_W-1:0]       w_tok_nx;
    logic [CNT_W-1:0]       w_idle_nx;
    logic                   w_settle_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The window spans the incoming word and the previous one, so offset 0
    // selects the previous word and a word reaches the decoder outputs three
    // edges after it is presented.
    assign w_win = TMDS_WORD_W'({i_din, r_din_prev} >> r_offset);
    assign w_tok = is_token(r_word_al);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din_prev <= '0;
            r_word_al  <= '0;
            r_state    <= SEARCH;
            r_offset   <= '0;
            r_tok_run  <= '0;
            r_idle     <= '0;
            r_settle   <= 1'b0;
        end else begin
            r_din_prev <= i_din;
            r_word_al  <= w_win;
            r_state    <= w_state_nx;
            r_offset   <= w_offset_nx;
            r_tok_run  <= w_tok_nx;
            r_idle     <= w_idle_nx;
            r_settle   <= w_settle_nx;
        end
    end

    // A token always takes priority over a terminal idle count, so a token
    // arriving on the last idle word prevents the slip or unlock.
    always_comb begin
        w_state_nx  = r_state;
        w_offset_nx = r_offset;
        w_tok_nx    = r_tok_run;
        w_idle_nx   = r_idle;
        w_settle_nx = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_tok) begin
                    w_idle_nx = '0;
                    w_tok_nx  = sat_inc(r_tok_run);
                    if (r_tok_run == CNT_W'(LOCK_TOKENS - 1)) begin
                        w_state_nx = LOCKED;
                        w_tok_nx   = '0;
                    end
                end else if (r_idle == CNT_W'(SEARCH_WORDS - 1)) begin
                    w_state_nx  = SETTLE;
                    w_offset_nx = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    w_tok_nx    = '0;
                    w_idle_nx   = '0;
                end else begin
                    w_tok_nx  = '0;
                    w_idle_nx = sat_inc(r_idle);
                end
            end
            // Two frozen cycles flush words built with the old offset.
            SETTLE: begin
                w_settle_nx = ~r_settle;
                if (r_settle) w_state_nx = SEARCH;
            end
            LOCKED: begin
                if (w_tok) begin
                    w_idle_nx = '0;
                end else if (r_idle == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_state_nx = SEARCH;
                    w_tok_nx   = '0;
                    w_idle_nx  = '0;
                end else begin
                    w_idle_nx = sat_inc(r_idle);
                end
            end
            default: w_state_nx = SEARCH;
        endcase
    end

    assign o_word_al = r_word_al;
    assign o_locked  = (r_state == LOCKED);
    assign o_offset  = r_offset;

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS receive channel - word alignment, 10b->8b decode,
// data_en and ctrl0/ctrl1 recovery.
// Ports:
//   clk, rst_n            - pixel clock, asynchronous active-low reset
//   din                   - raw deserialized word, bit 0 received first
//   data_out, data_en     - decoded pixel byte and its valid flag
//   ctrl0_out, ctrl1_out  - recovered control bits (held during data)
//   locked, slip_offset   - alignment status and current window offset
// Optional (macro TMDS_DECODER_LOSS_CNT_EN):
//   loss_clr              - synchronous clear of loss_cnt
//   loss_cnt              - saturating count of lock losses
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 1024,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TMDS_WORD_W-1:0] din,
`ifdef TMDS_DECODER_LOSS_CNT_EN
    input  logic                   loss_clr,
    output logic [15:0]            loss_cnt,
`endif
    output logic [7:0]             data_out,
    output logic                   data_en,
    output logic                   ctrl0_out,
    output logic                   ctrl1_out,
    output logic                   locked,
    output logic [3:0]             slip_offset
);

    logic [TMDS_WORD_W-1:0] w_al;
    logic                   w_locked;
    logic [3:0]             w_offset;
    logic [7:0]             w_q;
    logic [6:0]             w_x;
    logic [7:0]             w_dec;
    logic                   w_is_tok;
    logic [1:0]             w_ctrl;

    logic [7:0]             r_data_out;
    logic                   r_data_en;
    logic                   r_ctrl0;
    logic                   r_ctrl1;

    tmds_word_aligner #(
        .LOCK_TOKENS (LOCK_TOKENS),
        .SEARCH_WORDS(SEARCH_WORDS),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_aligner (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_din    (din),
        .o_word_al(w_al),
        .o_locked (w_locked),
        .o_offset (w_offset)
    );

    // Bit 9 flags inverted data, bit 8 selects XOR (1) or XNOR (0) chaining.
    assign w_q   = w_al[9] ? ~w_al[7:0] : w_al[7:0];
    assign w_x   = w_q[7:1] ^ w_q[6:0];
    assign w_dec = {w_al[8] ? w_x : ~w_x, w_q[0]};

    assign w_is_tok = is_token(w_al);
    assign w_ctrl   = (w_al == CTRL_TOKEN_1) ? 2'b01 :
                      (w_al == CTRL_TOKEN_2) ? 2'b10 :
                      (w_al == CTRL_TOKEN_3) ? 2'b11 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_data_en  <= 1'b0;
            r_ctrl0    <= 1'b0;
            r_ctrl1    <= 1'b0;
        end else if (!w_locked) begin
            r_data_out <= '0;
            r_data_en  <= 1'b0;
            r_ctrl0    <= 1'b0;
            r_ctrl1    <= 1'b0;
        end else if (w_is_tok) begin
            r_data_out <= '0;
            r_data_en  <= 1'b0;
            {r_ctrl1, r_ctrl0} <= w_ctrl;
        end else begin
            r_data_out <= w_dec;
            r_data_en  <= 1'b1;
        end
    end

`ifdef TMDS_DECODER_LOSS_CNT_EN
    logic        r_locked_d;
    logic [15:0] r_loss_cnt;

    // A falling edge of locked marks a LOCKED->SEARCH transition; reset
    // clears both registers so it never counts as a loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked_d <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            r_locked_d <= w_locked;
            if (loss_clr) r_loss_cnt <= '0;
            else if (r_locked_d && !w_locked && !(&r_loss_cnt)) r_loss_cnt <= r_loss_cnt + 16'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

    assign data_out    = r_data_out;
    assign data_en     = r_data_en;
    assign ctrl0_out   = r_ctrl0;
    assign ctrl1_out   = r_ctrl1;
    assign locked      = w_locked;
    assign slip_offset = w_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed self-checking bench for tmds_decoder.
module tb_tmds_decoder;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic [7:0] data_out;
    logic       data_en;
    logic       ctrl0_out;
    logic       ctrl1_out;
    logic       locked;
    logic [3:0] slip_offset;
`ifdef TMDS_DECODER_LOSS_CNT_EN
    logic        loss_clr = 1'b0;
    logic [15:0] loss_cnt;
`endif

    int         n_vec = 0;
    int         n_bad = 0;
    int         tx_off = 0;
    logic [9:0] prev = '0;
    int         disp = 0;
    logic       sb_on = 1'b0;
    logic       lost = 1'b0;
    logic [7:0] exp_q[$];

    tmds_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
`ifdef TMDS_DECODER_LOSS_CNT_EN
        .loss_clr   (loss_clr),
        .loss_cnt   (loss_cnt),
`endif
        .data_out   (data_out),
        .data_en    (data_en),
        .ctrl0_out  (ctrl0_out),
        .ctrl1_out  (ctrl1_out),
        .locked     (locked),
        .slip_offset(slip_offset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one transmitted word, shifted so the decoder must settle at
    // window offset tx_off; then advance one edge and sample 1 time unit later.
    task automatic step(input logic [9:0] w);
        logic [19:0] s;
        s = {w, prev} >> (10 - tx_off);
        din = (tx_off == 0) ? w : s[9:0];
        prev = w;
        @(posedge clk);
        #1;
        if (sb_on) begin
            if (!locked) lost = 1'b1;
            if (data_en) begin
                chk("frame_q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("frame_px", data_out, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input int off, input logic [9:0] w);
        rst_n = 1'b0;
        tx_off = off;
        prev = w;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference DVI TMDS encoder with running disparity in disp.
    task automatic enc(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp = disp + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp = disp - 2 * int'(!qm[8]) + n1q - n0q;
        end
    endtask

    initial begin
        int n;
        int t_lock;
        logic [3:0] last;
        int t_slip[$];
        int o_slip[$];
        int exp_t[3];
        logic [9:0] w;
        logic [7:0] px;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {data_out, data_en, ctrl1_out, ctrl0_out, locked, slip_offset}, 0);

        // Aligned token stream: 8th token counted on edge 10
        do_reset(0, TOK0);
        for (int i = 0; i < 9; i++) step(TOK0);
        chk("t1_not_locked_e9", locked, 0);
        step(TOK0);
        chk("t1_locked_e10", locked, 1);
        step(TOK0);
        chk("t1_ctrl", {ctrl1_out, ctrl0_out}, 2'b00);
        chk("t1_data_en", data_en, 0);
        chk("t1_offset", slip_offset, 0);

        // Data decode and control hold
        step(10'h100);
        step(10'h200);
        step(TOK1);
        chk("t3_d0_en", data_en, 1);
        chk("t3_d0_val", data_out, 8'h00);
        step(10'h100);
        chk("t3_d1_en", data_en, 1);
        chk("t3_d1_val", data_out, 8'hFF);
        step(TOK1);
        chk("t3_tok_en", data_en, 0);
        chk("t3_tok_ctrl", {ctrl1_out, ctrl0_out}, 2'b01);
        chk("t3_tok_data", data_out, 8'h00);
        step(TOK1);
        chk("t3_hold_en", data_en, 1);
        chk("t3_hold_ctrl0", ctrl0_out, 1);

        // Stream rotated by 3 bits: slips at edges 1024, 2050, 3076, lock at 3086
        do_reset(3, TOK0);
        last = 4'd0;
        t_lock = 0;
        n = 0;
        while (!locked && n < 5000) begin
            step(TOK0);
            n++;
            if (slip_offset != last) begin
                t_slip.push_back(n);
                o_slip.push_back(int'(slip_offset));
                last = slip_offset;
            end
        end
        t_lock = n;
        exp_t = '{1024, 2050, 3076};
        chk("t2_num_slips", t_slip.size(), 3);
        for (int i = 0; i < t_slip.size() && i < 3; i++) begin
            chk("t2_slip_time", t_slip[i], exp_t[i]);
            chk("t2_slip_offset", o_slip[i], i + 1);
        end
        chk("t2_locked", locked, 1);
        chk("t2_lock_time", t_lock, 3086);
        chk("t2_offset", slip_offset, 3);

        // Lock timeout after 4096 non-token words, offset retained
        for (int i = 0; i < 4090; i++) step(10'h100);
        chk("t4_still_locked", locked, 1);
        chk("t4_data_en", data_en, 1);
        for (int i = 0; i < 10; i++) step(10'h100);
        chk("t4_unlocked", locked, 0);
        chk("t4_offset_kept", slip_offset, 3);
        chk("t4_data_en_off", data_en, 0);
`ifdef TMDS_DECODER_LOSS_CNT_EN
        chk("t4_loss_cnt", loss_cnt, 1);
        loss_clr = 1'b1;
        step(10'h100);
        loss_clr = 1'b0;
        chk("t4_loss_clr", loss_cnt, 0);
`endif

        // Encoded video at offset 7: 8 lines of 800 words, 160 blank each
        do_reset(7, TOK0);
        n = 0;
        while (!locked && n < 9000) begin
            step(TOK0);
            n++;
        end
        chk("t5_locked", locked, 1);
        chk("t5_offset", slip_offset, 7);
        sb_on = 1'b1;
        for (int ln = 0; ln < 8; ln++) begin
            disp = 0;
            for (int i = 0; i < 160; i++) step(TOK0);
            for (int i = 0; i < 640; i++) begin
                px = 8'($urandom_range(0, 255));
                enc(px, w);
                exp_q.push_back(px);
                step(w);
            end
        end
        for (int i = 0; i < 6; i++) step(TOK0);
        sb_on = 1'b0;
        chk("t5_all_pixels_seen", exp_q.size(), 0);
        chk("t5_no_unlock", lost, 0);

        // Asynchronous reset while locked at offset 5
        do_reset(5, TOK3);
        n = 0;
        while (!locked && n < 7000) begin
            step(TOK3);
            n++;
        end
        step(TOK3);
        step(TOK3);
        chk("t6_locked", locked, 1);
        chk("t6_offset", slip_offset, 5);
        chk("t6_ctrl", {ctrl1_out, ctrl0_out}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {data_out, data_en, ctrl1_out, ctrl0_out, locked, slip_offset}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(TOK3);
        chk("t6_search_locked", locked, 0);
        chk("t6_search_offset", slip_offset, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
